// File: rtl/idelay_cal_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : idelay_cal_pkg
//  Description : Shared types and constants for the IDELAY tap calibration
//                controller: tap width, FSM state encoding and a helper that
//                picks the centre tap of a passing window.
//  Revision    : 1.0 - initial release
// ============================================================================
package idelay_cal_pkg;

    localparam int NTAPS = 32;
    localparam int TAP_W = $clog2(NTAPS);

    typedef logic [TAP_W-1:0] tap_t;
    // Lengths need one extra bit so a full-width window (NTAPS) is representable.
    typedef logic [TAP_W:0]   len_t;

    typedef enum logic [3:0] {
        ST_IDLE         = 4'd0,
        ST_WAIT_RDY     = 4'd1,
        ST_LOAD         = 4'd2,
        ST_SETTLE       = 4'd3,
        ST_SAMPLE       = 4'd4,
        ST_EVAL         = 4'd5,
        ST_FINAL_LOAD   = 4'd6,
        ST_FINAL_SETTLE = 4'd7,
        ST_DONE         = 4'd8
    } cal_state_t;

    // Centre of a window, rounding toward the window start for even lengths.
    // Caller guarantees len >= 1.
    function automatic tap_t eye_centre(input tap_t start, input len_t len);
        len_t half;
        half = (len - len_t'(1)) >> 1;
        return tap_t'(len_t'(start) + half);
    endfunction

endpackage
`default_nettype wire

// File: rtl/idelay_eye_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : idelay_eye_tracker
//  Description : Longest-run tracker for the tap sweep. One strobe per tap,
//                in ascending tap order. Keeps the current passing run and the
//                best run seen so far; ties keep the earlier window.
//  Ports       : clk, rst_n      - clock, synchronous active-low reset
//                clear           - drop all run state (sweep restart)
//                strobe, pass    - one tap result, pass=1 for a clean tap
//                tap             - tap the result belongs to
//                best_start/len  - registered best window
//                best_*_nxt      - best window including this cycle's strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module idelay_eye_tracker
    import idelay_cal_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic strobe,
    input  logic pass,
    input  tap_t tap,
    output tap_t best_start,
    output len_t best_len,
    output tap_t best_start_nxt,
    output len_t best_len_nxt
);

    tap_t cur_start_q, cur_start_d;
    len_t cur_len_q,   cur_len_d;
    tap_t best_start_q, best_start_d;
    len_t best_len_q,   best_len_d;

    always_comb begin
        cur_start_d  = cur_start_q;
        cur_len_d    = cur_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        if (clear) begin
            cur_start_d  = '0;
            cur_len_d    = '0;
            best_start_d = '0;
            best_len_d   = '0;
        end else if (strobe) begin
            if (pass) begin
                if (cur_len_q == '0) begin
                    cur_start_d = tap;
                end
                cur_len_d = cur_len_q + len_t'(1);
                // Strictly greater: an equal-length later window never replaces.
                if (cur_len_d > best_len_q) begin
                    best_start_d = cur_start_d;
                    best_len_d   = cur_len_d;
                end
            end else begin
                cur_len_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else begin
            cur_start_q  <= cur_start_d;
            cur_len_q    <= cur_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
        end
    end

    assign best_start     = best_start_q;
    assign best_len       = best_len_q;
    assign best_start_nxt = best_start_d;
    assign best_len_nxt   = best_len_d;

endmodule
`default_nettype wire

// File: rtl/idelay_tap_cal.sv
`default_nettype none
// ============================================================================
//  Module      : idelay_tap_cal
//  Description : Calibration controller for an IDELAYE2/ODELAYE2 in VAR_LOAD
//                mode. Sweeps every tap, scores it from sample-compare beats,
//                finds the longest passing window and loads its centre.
//  Ports       : clk, rst_n          - clock, synchronous active-low reset
//                start               - 1-cycle request, ignored while busy
//                idelay_rdy          - IDELAYCTRL RDY; low restarts the sweep
//                smp_valid/smp_match - per-beat compare result
//                cntvalueout         - delay element read-back
//                cntvaluein, ld      - delay element load interface
//                busy, done, fail    - status (done/fail are levels)
//                eye_start, eye_len  - best window found
//                cal_tap             - tap finally loaded
//  Revision    : 1.0 - initial release
// ============================================================================
module idelay_tap_cal
    import idelay_cal_pkg::*;
#(
    parameter int SETTLE_CYC  = 8,
    parameter int SAMPLE_CYC  = 16,
    parameter int MIN_EYE     = 3,
    parameter int DEFAULT_TAP = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             idelay_rdy,
    input  logic             smp_valid,
    input  logic             smp_match,
    input  logic [TAP_W-1:0] cntvalueout,
    output logic [TAP_W-1:0] cntvaluein,
    output logic             ld,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [TAP_W-1:0] eye_start,
    output logic [TAP_W:0]   eye_len,
    output logic [TAP_W-1:0] cal_tap
);

    localparam int   SETTLE_W    = $clog2(SETTLE_CYC + 1);
    localparam int   SAMPLE_W    = $clog2(SAMPLE_CYC + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(SAMPLE_CYC - 1);
    localparam len_t LAST_TAP    = len_t'(NTAPS - 1);
    localparam len_t MIN_EYE_L   = len_t'(MIN_EYE);
    localparam tap_t DEF_TAP     = tap_t'(DEFAULT_TAP);

    cal_state_t          state_q, state_d;
    len_t                tap_q, tap_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [SAMPLE_W-1:0] sample_cnt_q, sample_cnt_d;
    logic                tap_bad_q, tap_bad_d;
    tap_t                cntvaluein_q, cntvaluein_d;
    logic                ld_q, ld_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                fail_q, fail_d;
    tap_t                eye_start_q, eye_start_d;
    len_t                eye_len_q, eye_len_d;
    tap_t                cal_tap_q, cal_tap_d;

    logic trk_clear, trk_strobe;
    tap_t best_start, best_start_nxt;
    len_t best_len, best_len_nxt;

    idelay_eye_tracker u_tracker (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (trk_clear),
        .strobe         (trk_strobe),
        .pass           (~tap_bad_q),
        .tap            (tap_t'(tap_q)),
        .best_start     (best_start),
        .best_len       (best_len),
        .best_start_nxt (best_start_nxt),
        .best_len_nxt   (best_len_nxt)
    );

    always_comb begin
        state_d      = state_q;
        tap_d        = tap_q;
        settle_cnt_d = settle_cnt_q;
        sample_cnt_d = sample_cnt_q;
        tap_bad_d    = tap_bad_q;
        cntvaluein_d = cntvaluein_q;
        done_d       = done_q;
        fail_d       = fail_q;
        eye_start_d  = eye_start_q;
        eye_len_d    = eye_len_q;
        cal_tap_d    = cal_tap_q;
        trk_clear    = 1'b0;
        trk_strobe   = 1'b0;

        if (!idelay_rdy && (state_q inside {ST_LOAD, ST_SETTLE, ST_SAMPLE, ST_EVAL,
                                            ST_FINAL_LOAD, ST_FINAL_SETTLE})) begin
            // Delay line lost its reference: everything measured so far is suspect.
            state_d = ST_WAIT_RDY;
            tap_d   = '0;
            fail_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_WAIT_RDY;
                        tap_d   = '0;
                        done_d  = 1'b0;
                        fail_d  = 1'b0;
                    end
                end
                ST_WAIT_RDY: begin
                    trk_clear = 1'b1;
                    tap_d     = '0;
                    if (idelay_rdy) begin
                        state_d      = ST_LOAD;
                        cntvaluein_d = '0;
                    end
                end
                ST_LOAD: begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = '0;
                end
                ST_SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        if (cntvalueout == cntvaluein_q) begin
                            state_d      = ST_SAMPLE;
                            sample_cnt_d = '0;
                            tap_bad_d    = 1'b0;
                        end else begin
                            state_d      = ST_FINAL_LOAD;
                            fail_d       = 1'b1;
                            cal_tap_d    = DEF_TAP;
                            cntvaluein_d = DEF_TAP;
                            eye_start_d  = best_start;
                            eye_len_d    = best_len;
                        end
                    end else begin
                        settle_cnt_d = settle_cnt_q + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (smp_valid) begin
                        if (!smp_match) begin
                            tap_bad_d = 1'b1;
                        end
                        if (sample_cnt_q == SAMPLE_LAST) begin
                            state_d = ST_EVAL;
                        end else begin
                            sample_cnt_d = sample_cnt_q + 1'b1;
                        end
                    end
                end
                ST_EVAL: begin
                    trk_strobe = 1'b1;
                    if (tap_q == LAST_TAP) begin
                        // Tracker look-ahead includes this last tap's result.
                        eye_start_d = best_start_nxt;
                        eye_len_d   = best_len_nxt;
                        if (best_len_nxt >= MIN_EYE_L) begin
                            cal_tap_d = eye_centre(best_start_nxt, best_len_nxt);
                            fail_d    = 1'b0;
                        end else begin
                            cal_tap_d = DEF_TAP;
                            fail_d    = 1'b1;
                        end
                        cntvaluein_d = cal_tap_d;
                        state_d      = ST_FINAL_LOAD;
                    end else begin
                        tap_d        = tap_q + len_t'(1);
                        cntvaluein_d = tap_t'(tap_q + len_t'(1));
                        state_d      = ST_LOAD;
                    end
                end
                ST_FINAL_LOAD: begin
                    state_d      = ST_FINAL_SETTLE;
                    settle_cnt_d = '0;
                end
                ST_FINAL_SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        if (cntvalueout != cntvaluein_q) begin
                            fail_d = 1'b1;
                        end
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    // A start arriving in the same cycle DONE retires is honoured.
                    if (start) begin
                        state_d = ST_WAIT_RDY;
                        tap_d   = '0;
                        done_d  = 1'b0;
                        fail_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        ld_d   = (state_d == ST_LOAD) || (state_d == ST_FINAL_LOAD);
        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tap_q        <= '0;
            settle_cnt_q <= '0;
            sample_cnt_q <= '0;
            tap_bad_q    <= 1'b0;
            cntvaluein_q <= '0;
            ld_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            eye_start_q  <= '0;
            eye_len_q    <= '0;
            cal_tap_q    <= '0;
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            settle_cnt_q <= settle_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            tap_bad_q    <= tap_bad_d;
            cntvaluein_q <= cntvaluein_d;
            ld_q         <= ld_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            eye_start_q  <= eye_start_d;
            eye_len_q    <= eye_len_d;
            cal_tap_q    <= cal_tap_d;
        end
    end

    assign cntvaluein = cntvaluein_q;
    assign ld         = ld_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fail       = fail_q;
    assign eye_start  = eye_start_q;
    assign eye_len    = eye_len_q;
    assign cal_tap    = cal_tap_q;

endmodule
`default_nettype wire
